// File: rtl/captouch_scan_scheduler_pkg.sv
// rtl/captouch_scan_scheduler_pkg.sv - shared types and helpers for the touch-pad scan scheduler
package captouch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISCHARGE,
    ST_CHARGE,
    ST_EVAL,
    ST_NEXT
  } state_t;

  function automatic int pad_idx_w(input int num_pads);
    return (num_pads < 2) ? 1 : $clog2(num_pads);
  endfunction

  // 32-bit arithmetic keeps baseline + baseline/2^shift free of overflow for any CNT_W up to 31
  function automatic logic [31:0] touch_threshold(input logic [31:0] baseline, input int shift);
    return baseline + (baseline >> shift);
  endfunction

endpackage

// File: rtl/captouch_scan_scheduler_if.sv
// rtl/captouch_scan_scheduler_if.sv - pad I/O and user-side signals of the scan scheduler
interface captouch_scan_scheduler_if
  import captouch_pkg::*;
#(
  parameter int NUM_PADS = 4,
  parameter int CNT_W    = 15,
  parameter int PAD_W    = pad_idx_w(NUM_PADS)
);
  logic                enable;
  logic                recal;
  logic [NUM_PADS-1:0] cap_in;
  logic [NUM_PADS-1:0] cap_out;
  logic [NUM_PADS-1:0] cap_oe;
  logic [NUM_PADS-1:0] btn;
  logic [CNT_W-1:0]    meas_count;
  logic [PAD_W-1:0]    meas_pad;
  logic                meas_valid;
  logic                scan_done;
  logic                busy;

  modport slave (
    input  enable, recal, cap_in,
    output cap_out, cap_oe, btn, meas_count, meas_pad, meas_valid, scan_done, busy
  );

  modport master (
    output enable, recal, cap_in,
    input  cap_out, cap_oe, btn, meas_count, meas_pad, meas_valid, scan_done, busy
  );
endinterface

// File: rtl/captouch_scan_scheduler_pad_filter.sv
// rtl/captouch_scan_scheduler_pad_filter.sv - per-pad baseline, touch decision and debouncer
module captouch_pad_filter
  import captouch_pkg::*;
#(
  parameter int CNT_W      = 15,
  parameter int HYST_SHIFT = 3,
  parameter int DEBOUNCE   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_eval,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_timeout,
  input  logic             i_recal,
  output logic             o_btn
);
  logic [CNT_W-1:0]    r_baseline;
  logic                r_base_valid;
  logic [DEBOUNCE-1:0] r_hist;
  logic                r_btn;
  logic [31:0]         w_threshold;
  logic                w_raw_touch;
  logic [DEBOUNCE-1:0] w_hist_next;

  assign w_threshold = touch_threshold(32'(r_baseline), HYST_SHIFT);
  assign w_raw_touch = r_base_valid && (i_timeout || (32'(i_count) > w_threshold));
  assign w_hist_next = {r_hist[DEBOUNCE-2:0], w_raw_touch};
  assign o_btn       = r_btn;

  // recal outranks a coincident evaluation: nothing from that sample is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baseline   <= '0;
      r_base_valid <= 1'b0;
      r_hist       <= '0;
      r_btn        <= 1'b0;
    end else if (i_recal) begin
      r_base_valid <= 1'b0;
      r_hist       <= '0;
      r_btn        <= 1'b0;
    end else if (i_eval) begin
      if (!r_base_valid) begin
        r_baseline   <= i_count;
        r_base_valid <= 1'b1;
      end
      r_hist <= w_hist_next;
      if (&w_hist_next) begin
        r_btn <= 1'b1;
      end else if (!(|w_hist_next)) begin
        r_btn <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/captouch_scan_scheduler.sv
// rtl/captouch_scan_scheduler.sv - round-robin charge-time scanner sharing one counter across all pads
module captouch_scan_scheduler
  import captouch_pkg::*;
#(
  parameter int NUM_PADS         = 4,
  parameter int CNT_W            = 15,
  parameter int DISCHARGE_CYCLES = 10,
  parameter int TIMEOUT          = 32767,
  parameter int HYST_SHIFT       = 3,
  parameter int DEBOUNCE         = 4
) (
  input logic                     clk,
  input logic                     reset,
  captouch_scan_scheduler_if.slave io_bus
);
  localparam int               PAD_W        = pad_idx_w(NUM_PADS);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [PAD_W-1:0] PAD_LAST     = PAD_W'(NUM_PADS - 1);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [PAD_W-1:0]    r_pad, w_pad_next;
  logic [NUM_PADS-1:0] r_sync1, r_sync2;
  logic [CNT_W-1:0]    r_meas_count;
  logic [PAD_W-1:0]    r_meas_pad;
  logic                w_load_meas;
  logic                w_sel_in;
  logic                w_eval;
  logic                w_timeout;
  logic [NUM_PADS-1:0] w_charge_mask;
  logic [NUM_PADS-1:0] w_btn;

  assign w_sel_in  = r_sync2[r_pad];
  assign w_eval    = (r_state == ST_EVAL);
  assign w_timeout = (r_cnt == CNT_TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pad        <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_meas_count <= '0;
      r_meas_pad   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pad   <= w_pad_next;
      r_sync1 <= io_bus.cap_in;
      r_sync2 <= r_sync1;
      if (w_load_meas) begin
        r_meas_count <= r_cnt;
        r_meas_pad   <= r_pad;
      end
    end
  end

  // CHARGE only exits on a cycle that does not increment, so r_cnt already holds the final count
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pad_next   = r_pad;
    w_load_meas  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.enable) begin
          w_state_next = ST_DISCHARGE;
          w_cnt_next   = '0;
          w_pad_next   = '0;
        end
      end
      ST_DISCHARGE: begin
        if (r_cnt == CNT_DIS_LAST) begin
          w_state_next = ST_CHARGE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_CHARGE: begin
        if (w_sel_in || w_timeout) begin
          w_state_next = ST_EVAL;
          w_load_meas  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_pad_next = (r_pad == PAD_LAST) ? '0 : r_pad + PAD_W'(1);
        w_cnt_next = '0;
        if (io_bus.enable) begin
          w_state_next = ST_DISCHARGE;
        end else begin
          w_state_next = ST_IDLE;
          w_pad_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    captouch_pad_filter #(
      .CNT_W      (CNT_W),
      .HYST_SHIFT (HYST_SHIFT),
      .DEBOUNCE   (DEBOUNCE)
    ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .i_eval    (w_eval && (r_pad == PAD_W'(g))),
      .i_count   (r_cnt),
      .i_timeout (w_timeout),
      .i_recal   (io_bus.recal),
      .o_btn     (w_btn[g])
    );
  end

  assign w_charge_mask     = (r_state == ST_CHARGE) ? (NUM_PADS'(1) << r_pad) : '0;
  assign io_bus.cap_out    = '0;
  assign io_bus.cap_oe     = ~w_charge_mask;
  assign io_bus.btn        = w_btn;
  assign io_bus.meas_count = r_meas_count;
  assign io_bus.meas_pad   = r_meas_pad;
  assign io_bus.meas_valid = w_eval;
  assign io_bus.scan_done  = (r_state == ST_NEXT) && (r_pad == PAD_LAST);
  assign io_bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_captouch_scan_scheduler.sv
// tb/tb_captouch_scan_scheduler.sv - directed scan vectors plus recal, enable-drop and reset corner sequences
module tb_captouch_scan_scheduler;
  localparam int NP  = 4;
  localparam int CW  = 15;
  localparam int TO  = 300;
  localparam int NEV = 10000;
  localparam int NV  = 27;

  typedef struct {
    int         dly [NP];
    int         cnt [NP];
    logic [3:0] btn;
    bit         recal;
  } scan_vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pad_dly [NP];
  int   pad_cnt [NP];
  logic [NP-1:0] pad_in;
  scan_vec_t vecs [NV];

  always #5 clk = ~clk;

  captouch_scan_scheduler_if #(.NUM_PADS(NP), .CNT_W(CW)) bus ();

  captouch_scan_scheduler #(
    .NUM_PADS         (NP),
    .CNT_W            (CW),
    .DISCHARGE_CYCLES (10),
    .TIMEOUT          (TO),
    .HYST_SHIFT       (3),
    .DEBOUNCE         (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  // pad model: input rises pad_dly cycles after its drive is released
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (bus.cap_oe[p]) pad_cnt[p] = 0;
      else               pad_cnt[p] = pad_cnt[p] + 1;
      pad_in[p] = (pad_cnt[p] > pad_dly[p]);
    end
    bus.cap_in = pad_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_meas(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      seen = bus.meas_valid;
    end
    chk({tag, " meas_valid seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_oe_low(input int p);
    bit seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      seen = !bus.cap_oe[p];
    end
    chk($sformatf("pad%0d charge start seen", p), 32'(seen), 32'd1);
  endtask

  function automatic scan_vec_t mk(input int d0, d1, d2, d3, input int c0, c1, c2, c3,
                                   input logic [3:0] b, input bit r);
    scan_vec_t v;
    v.dly   = '{d0, d1, d2, d3};
    v.cnt   = '{c0, c1, c2, c3};
    v.btn   = b;
    v.recal = r;
    return v;
  endfunction

  task automatic run_scan(input int idx, input scan_vec_t v);
    pad_dly = v.dly;
    for (int p = 0; p < NP; p++) begin
      wait_meas($sformatf("scan%0d pad%0d", idx, p));
      chk($sformatf("scan%0d meas_pad", idx), 32'(bus.meas_pad), 32'(p));
      chk($sformatf("scan%0d pad%0d meas_count", idx, p), 32'(bus.meas_count), 32'(v.cnt[p]));
      if (v.recal && p == 0) bus.recal = 1'b1;
      @(negedge clk);
      bus.recal = 1'b0;
      if (v.recal && p == 0) chk($sformatf("scan%0d btn after recal", idx), 32'(bus.btn), 32'd0);
      chk($sformatf("scan%0d pad%0d scan_done", idx, p), 32'(bus.scan_done), 32'(p == NP - 1));
    end
    chk($sformatf("scan%0d btn", idx), 32'(bus.btn), 32'(v.btn));
  endtask

  initial begin
    vecs[0]  = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0000, 0);
    vecs[1]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0000, 0);
    vecs[2]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0000, 0);
    vecs[3]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0000, 0);
    vecs[4]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0100, 0);
    vecs[5]  = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0100, 0);
    vecs[6]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0100, 0);
    vecs[7]  = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0100, 0);
    vecs[8]  = mk(20, 20, 30, 20,  22, 22, 32, 22,  4'b0100, 0);
    vecs[9]  = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0100, 0);
    vecs[10] = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0100, 0);
    vecs[11] = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0100, 0);
    vecs[12] = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0000, 0);
    vecs[13] = mk(20, NEV, 20, 20, 22, TO, 22, 22,  4'b0000, 0);
    vecs[14] = mk(20, NEV, 20, 20, 22, TO, 22, 22,  4'b0000, 0);
    vecs[15] = mk(20, NEV, 20, 20, 22, TO, 22, 22,  4'b0000, 0);
    vecs[16] = mk(20, NEV, 20, 20, 22, TO, 22, 22,  4'b0010, 0);
    vecs[17] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0010, 0);
    vecs[18] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0010, 0);
    vecs[19] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0010, 0);
    vecs[20] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0001, 0);
    vecs[21] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0000, 1);
    vecs[22] = mk(20, 20, 20, 20,  22, 22, 22, 22,  4'b0000, 0);
    vecs[23] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0000, 0);
    vecs[24] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0000, 0);
    vecs[25] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0000, 0);
    vecs[26] = mk(30, 20, 20, 20,  32, 22, 22, 22,  4'b0001, 0);

    pad_dly     = '{20, 20, 20, 20};
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.recal   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cap_oe", 32'(bus.cap_oe), 32'hF);
    chk("reset cap_out", 32'(bus.cap_out), 32'h0);
    chk("reset btn", 32'(bus.btn), 32'h0);
    chk("reset meas_count", 32'(bus.meas_count), 32'd0);
    chk("reset meas_valid", 32'(bus.meas_valid), 32'd0);
    chk("reset scan_done", 32'(bus.scan_done), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_scan(i, vecs[i]);

    // enable dropped while pad 1 is charging
    pad_dly = '{20, 20, 20, 20};
    wait_meas("drop pad0");
    chk("drop pad0 meas_pad", 32'(bus.meas_pad), 32'd0);
    wait_oe_low(1);
    bus.enable = 1'b0;
    wait_meas("drop pad1");
    chk("drop meas_pad", 32'(bus.meas_pad), 32'd1);
    chk("drop meas_count", 32'(bus.meas_count), 32'd22);
    @(negedge clk);
    chk("drop next busy", 32'(bus.busy), 32'd1);
    chk("drop next scan_done", 32'(bus.scan_done), 32'd0);
    @(negedge clk);
    chk("drop idle busy", 32'(bus.busy), 32'd0);
    chk("drop idle cap_oe", 32'(bus.cap_oe), 32'hF);
    chk("drop btn held", 32'(bus.btn), 32'b0001);
    repeat (5) @(negedge clk);
    chk("drop stays idle", 32'(bus.busy), 32'd0);

    // reset asserted in the middle of a charge phase
    bus.enable = 1'b1;
    wait_oe_low(0);
    repeat (2) @(negedge clk);
    chk("pre-reset cap_oe", 32'(bus.cap_oe), 32'hE);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset cap_oe", 32'(bus.cap_oe), 32'hF);
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset btn", 32'(bus.btn), 32'h0);
    chk("midreset meas_count", 32'(bus.meas_count), 32'd0);
    chk("midreset meas_pad", 32'(bus.meas_pad), 32'd0);
    chk("midreset meas_valid", 32'(bus.meas_valid), 32'd0);
    chk("midreset scan_done", 32'(bus.scan_done), 32'd0);
    bus.enable = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-reset idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
